// File: rtl/cp0_irq.sv
// cp0_irq: CP0 coprocessor with NUM_IRQ external interrupt lines.
//
// Purpose
//   Holds the Status, Cause, EPC and EBase registers. It senses each external
//   interrupt line as a latched rising edge or as a plain level, masks the
//   pending lines with Status.IM and picks the highest pending index. It takes
//   the interrupt through the pipeline's forced-jump path and returns from the
//   handler on ERET.
//   Pipeline timing: reads happen in ID, mtc0 writes in EXE, and take/ERET
//   in MEM.
//
// Optional feature
//   Define CP0_TIMER_EN to add Count (reg 9) and Compare (reg 11). The timer
//   uses the IP/IM slot just above the external lines, so it has the highest
//   priority. Without the macro, regs 9/11 and the timer IP/IM bits read 0.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   oper[1:0]      00 none, 01 mtc0 store, 10 eret, 11 treated as none
//   addr_r/data_r  read index / registered read data (1-cycle latency)
//   addr_w/data_w  write index / write data (used when oper = store)
//   ir_en          pipeline can accept an interrupt this cycle
//   ir_in          external interrupt lines
//   ret_addr       PC saved to EPC when an interrupt is taken
//   jump_en/addr   forced jump request/target (combinational)
//   exl            Status.EXL, high while a handler is active
module cp0_irq #(
   parameter int                 NUM_IRQ      = 4,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK    = '0,
   parameter logic [31:0]        HANDLER_BASE = 32'h0000_0020
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         oper,
   input  logic [4:0]         addr_r,
   output logic [31:0]        data_r,
   input  logic [4:0]         addr_w,
   input  logic [31:0]        data_w,
   input  logic               ir_en,
   input  logic [NUM_IRQ-1:0] ir_in,
   input  logic [31:0]        ret_addr,
   output logic               jump_en,
   output logic [31:0]        jump_addr,
   output logic               exl
);

   // Opcode values shared with the pipeline's mips_define.vh.
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_ERET  = 2'b10;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_EBASE   = 5'd15;

   // Architectural state
   logic               ie_q, ie_d;
   logic               exl_q, exl_d;
   logic [NUM_IRQ:0]   im_q, im_d;         // bit NUM_IRQ is the timer slot
   logic [4:0]         irq_id_q, irq_id_d;
   logic [31:0]        epc_q, epc_d;
   logic [31:0]        ebase_q, ebase_d;
   logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
   logic [NUM_IRQ-1:0] ir_prev_q;
   logic [31:0]        data_r_q, data_r_d;

   // Decoded per-cycle signals
   logic [NUM_IRQ:0]   ip;
   logic [NUM_IRQ:0]   pend_act;
   logic [4:0]         win_id;
   logic               take, do_eret, do_take, do_store;
   logic               tmr_pend;
   logic [31:0]        count_val, compare_val;

   // Edge lines report their latch; level lines pass straight through.
   always_comb begin
      ip = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         ip[i] = EDGE_MASK[i] ? edge_pend_q[i] : ir_in[i];
      end
      ip[NUM_IRQ] = tmr_pend;
   end

   assign pend_act = ip & im_q;

   // Ascending scan: the last hit, i.e. the highest index, wins.
   always_comb begin
      win_id = '0;
      for (int i = 0; i <= NUM_IRQ; i++) begin
         if (pend_act[i]) begin
            win_id = 5'(i);
         end
      end
   end

   assign take     = ir_en & ie_q & ~exl_q & (|pend_act);
   assign do_eret  = (oper == OP_ERET);
   // ERET has priority; the interrupt is re-evaluated next cycle.
   assign do_take  = take & ~do_eret;
   // The instruction whose store coincides with a take is flushed.
   assign do_store = (oper == OP_STORE) & ~do_take;

   always_comb begin
      jump_en   = 1'b0;
      jump_addr = 32'd0;
      if (do_eret) begin
         jump_en   = 1'b1;
         jump_addr = epc_q;
      end else if (do_take) begin
         jump_en   = 1'b1;
         jump_addr = ebase_q;
      end
   end

   assign exl    = exl_q;
   assign data_r = data_r_q;

   always_comb begin
      ie_d        = ie_q;
      exl_d       = exl_q;
      im_d        = im_q;
      irq_id_d    = irq_id_q;
      epc_d       = epc_q;
      ebase_d     = ebase_q;
      edge_pend_d = edge_pend_q;
      if (do_eret) begin
         exl_d = 1'b0;
      end else if (do_take) begin
         epc_d    = ret_addr;
         exl_d    = 1'b1;
         irq_id_d = win_id;
      end
      if (do_store) begin
         case (addr_w)
            REG_STATUS: begin
               ie_d  = data_w[0];
               exl_d = data_w[1];
               im_d  = data_w[8 +: NUM_IRQ+1];
`ifndef CP0_TIMER_EN
               im_d[NUM_IRQ] = 1'b0;
`endif
            end
            // Writing 0 to an IP bit clears that edge latch.
            REG_CAUSE: edge_pend_d = edge_pend_q & data_w[8 +: NUM_IRQ];
            REG_EPC:   epc_d = data_w;
            REG_EBASE: ebase_d = {data_w[31:2], 2'b00};
            default:   ;
         endcase
      end
      // A rising edge in the same cycle as a clear still sets the latch.
      edge_pend_d = (edge_pend_d | (ir_in & ~ir_prev_q)) & EDGE_MASK;
   end

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        tmr_pend_q, tmr_pend_d;

   always_comb begin
      count_d    = count_q + 32'd1;
      compare_d  = compare_q;
      tmr_pend_d = tmr_pend_q;
      if ((count_q == compare_q) && (compare_q != 32'd0)) begin
         tmr_pend_d = 1'b1;
      end
      if (do_store && (addr_w == REG_COUNT)) begin
         count_d = data_w;
      end
      if (do_store && (addr_w == REG_COMPARE)) begin
         compare_d  = data_w;
         tmr_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         tmr_pend_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         tmr_pend_q <= tmr_pend_d;
      end
   end

   assign tmr_pend    = tmr_pend_q;
   assign count_val   = count_q;
   assign compare_val = compare_q;
`else
   assign tmr_pend    = 1'b0;
   assign count_val   = 32'd0;
   assign compare_val = 32'd0;
`endif

   // The read mux sees pre-update values, so a same-cycle write returns old data.
   always_comb begin
      data_r_d = 32'd0;
      case (addr_r)
         REG_STATUS: begin
            data_r_d[0]                = ie_q;
            data_r_d[1]                = exl_q;
            data_r_d[8 +: NUM_IRQ+1]   = im_q;
         end
         REG_CAUSE: begin
            data_r_d[8 +: NUM_IRQ+1]   = ip;
            data_r_d[20:16]            = irq_id_q;
         end
         REG_EPC:     data_r_d = epc_q;
         REG_EBASE:   data_r_d = ebase_q;
         REG_COUNT:   data_r_d = count_val;
         REG_COMPARE: data_r_d = compare_val;
         default:     data_r_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ie_q        <= 1'b0;
         exl_q       <= 1'b0;
         im_q        <= '0;
         irq_id_q    <= 5'd0;
         epc_q       <= 32'd0;
         ebase_q     <= HANDLER_BASE;
         edge_pend_q <= '0;
         ir_prev_q   <= '0;
         data_r_q    <= 32'd0;
      end else begin
         ie_q        <= ie_d;
         exl_q       <= exl_d;
         im_q        <= im_d;
         irq_id_q    <= irq_id_d;
         epc_q       <= epc_d;
         ebase_q     <= ebase_d;
         edge_pend_q <= edge_pend_d;
         ir_prev_q   <= ir_in;
         data_r_q    <= data_r_d;
      end
   end

endmodule

// File: tb/tb_cp0_irq.sv
// tb_cp0_irq: directed bench for cp0_irq (NUM_IRQ=4, line 1 edge, others level).
// An architectural model tracks the register file and pending lines from the
// inputs alone. Each cycle it predicts jump_en/jump_addr/exl/data_r. Literal
// checks pin key points of the expected behaviour.
module tb_cp0_irq;
   localparam int                 NUM_IRQ   = 4;
   localparam logic [NUM_IRQ-1:0] EDGE_MASK = 4'b0010;
   localparam logic [31:0]        HBASE     = 32'h0000_0020;
   localparam logic [1:0]         OP_NONE   = 2'b00;
   localparam logic [1:0]         OP_STORE  = 2'b01;
   localparam logic [1:0]         OP_ERET   = 2'b10;

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst = 1'b1;
   logic [1:0]         oper = OP_NONE;
   logic [4:0]         addr_r = '0;
   logic [31:0]        data_r;
   logic [4:0]         addr_w = '0;
   logic [31:0]        data_w = '0;
   logic               ir_en = 1'b0;
   logic [NUM_IRQ-1:0] ir_in = '0;
   logic [31:0]        ret_addr = '0;
   logic               jump_en;
   logic [31:0]        jump_addr;
   logic               exl;

   cp0_irq #(.NUM_IRQ(NUM_IRQ), .EDGE_MASK(EDGE_MASK), .HANDLER_BASE(HBASE)) dut (
      .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
      .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
      .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .exl(exl)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model
   bit          model_known = 0;
   bit          m_ie, m_exl;
   bit          m_im[NUM_IRQ+1];
   bit          m_pend[NUM_IRQ];
   bit          m_prev[NUM_IRQ];
   int          m_irq_id;
   logic [31:0] m_epc, m_ebase, m_data_r;
   logic [31:0] m_count, m_compare;
   bit          m_tpend;

   function automatic bit m_ip(input int i);
      if (i == NUM_IRQ) return m_tpend;
      if (EDGE_MASK[i]) return m_pend[i];
      return ir_in[i];
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] r;
      r = 32'd0;
      case (a)
         5'd12: begin
            r[0] = m_ie;
            r[1] = m_exl;
            for (int i = 0; i <= NUM_IRQ; i++) r[8+i] = m_im[i];
         end
         5'd13: begin
            for (int i = 0; i <= NUM_IRQ; i++) r[8+i] = m_ip(i);
            r[20:16] = m_irq_id[4:0];
         end
         5'd14: r = m_epc;
         5'd15: r = m_ebase;
`ifdef CP0_TIMER_EN
         5'd9:  r = m_count;
         5'd11: r = m_compare;
`endif
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Search from the top: the first enabled pending line is the winner.
   task automatic m_decide(output bit tk, output int win);
      bit found;
      found = 0;
      win   = 0;
      for (int i = NUM_IRQ; i >= 0; i--) begin
         if (!found && m_ip(i) && m_im[i]) begin
            found = 1;
            win   = i;
         end
      end
      tk = ir_en && m_ie && !m_exl && found;
   endtask

   task automatic m_reset();
      m_ie = 0; m_exl = 0; m_irq_id = 0;
      m_epc = 0; m_ebase = HBASE; m_data_r = 0;
      m_count = 0; m_compare = 0; m_tpend = 0;
      for (int i = 0; i <= NUM_IRQ; i++) m_im[i] = 0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         m_pend[i] = 0;
         m_prev[i] = 0;
      end
      model_known = 1;
   endtask

   task automatic m_step();
      bit          tk, er, st, t_hit;
      int          win;
      logic [31:0] rd, nx_count;
      bit          rise[NUM_IRQ];
      if (rst) begin
         m_reset();
         return;
      end
      rd = m_read(addr_r);
      m_decide(tk, win);
      er = (oper == OP_ERET);
      if (er) tk = 0;
      st = (oper == OP_STORE) && !tk;
      t_hit = (m_count == m_compare) && (m_compare != 0);
      for (int i = 0; i < NUM_IRQ; i++) rise[i] = ir_in[i] && !m_prev[i];
      if (er) m_exl = 0;
      else if (tk) begin
         m_epc    = ret_addr;
         m_exl    = 1;
         m_irq_id = win;
      end
      nx_count = m_count + 1;
      if (st) begin
         case (addr_w)
            5'd12: begin
               m_ie  = data_w[0];
               m_exl = data_w[1];
               for (int i = 0; i < NUM_IRQ; i++) m_im[i] = data_w[8+i];
`ifdef CP0_TIMER_EN
               m_im[NUM_IRQ] = data_w[8+NUM_IRQ];
`endif
            end
            5'd13: for (int i = 0; i < NUM_IRQ; i++) if (!data_w[8+i]) m_pend[i] = 0;
            5'd14: m_epc = data_w;
            5'd15: m_ebase = data_w & 32'hFFFF_FFFC;
            default: ;
         endcase
      end
      for (int i = 0; i < NUM_IRQ; i++) if (EDGE_MASK[i] && rise[i]) m_pend[i] = 1;
`ifdef CP0_TIMER_EN
      if (st && addr_w == 5'd9) nx_count = data_w;
      if (t_hit) m_tpend = 1;
      if (st && addr_w == 5'd11) begin
         m_compare = data_w;
         m_tpend   = 0;
      end
      m_count = nx_count;
`endif
      for (int i = 0; i < NUM_IRQ; i++) m_prev[i] = ir_in[i];
      m_data_r = rd;
   endtask

   // One cycle: compare DUT outputs against the model, advance both.
   task automatic tick();
      bit          tk;
      int          win;
      logic        exp_je;
      logic [31:0] exp_ja;
      #1;
      if (model_known) begin
         m_decide(tk, win);
         exp_je = 1'b0;
         exp_ja = 32'd0;
         if (oper == OP_ERET) begin
            exp_je = 1'b1;
            exp_ja = m_epc;
         end else if (tk) begin
            exp_je = 1'b1;
            exp_ja = m_ebase;
         end
         chk("jump_en", {31'd0, jump_en}, {31'd0, exp_je});
         chk("jump_addr", jump_addr, exp_ja);
         chk("exl", {31'd0, exl}, {31'd0, m_exl});
         chk("data_r", data_r, m_data_r);
      end
      m_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Driver tasks
   task automatic store(input logic [4:0] a, input logic [31:0] d);
      oper = OP_STORE; addr_w = a; data_w = d;
      tick();
      oper = OP_NONE;
   endtask

   task automatic eret();
      oper = OP_ERET;
      tick();
      oper = OP_NONE;
   endtask

   task automatic read_lit(input string name, input logic [4:0] a, input logic [31:0] exp);
      addr_r = a;
      tick();
      chk(name, data_r, exp);
   endtask

   task automatic jump_lit(input string name, input logic en, input logic [31:0] addr);
      #1;
      chk({name, "_en"}, {31'd0, jump_en}, {31'd0, en});
      if (en) chk({name, "_addr"}, jump_addr, addr);
   endtask

   initial begin
      int hit_n;
      // Reset
      tick();
      tick();
      rst = 1'b0;

      // 1: reset values
      read_lit("rst_status", 5'd12, 32'h0);
      read_lit("rst_cause", 5'd13, 32'h0);
      read_lit("rst_epc", 5'd14, 32'h0);
      read_lit("rst_ebase", 5'd15, 32'h20);

      // 2: edge line 1 take
      store(5'd12, 32'h0000_0301);
      ir_en = 1'b1; ret_addr = 32'h100; ir_in[1] = 1'b1;
      tick();
      ir_in[1] = 1'b0;
      jump_lit("take1", 1'b1, 32'h20);
      tick();
      chk("exl_take1", {31'd0, exl}, 32'd1);
      read_lit("epc_take1", 5'd14, 32'h100);
      read_lit("cause_take1", 5'd13, 32'h0001_0200);

      // 3: line 0 during handler, ERET, then take of the still-asserted level line
      store(5'd13, 32'h0);
      ir_in[0] = 1'b1;
      jump_lit("no_take_in_handler", 1'b0, 32'h0);
      tick();
      oper = OP_ERET;
      jump_lit("eret1", 1'b1, 32'h100);
      tick();
      oper = OP_NONE;
      chk("exl_eret1", {31'd0, exl}, 32'd0);
      ret_addr = 32'h200;
      jump_lit("take_line0", 1'b1, 32'h20);
      tick();
      read_lit("cause_line0", 5'd13, 32'h0000_0100);
      ir_in = '0;
      eret();
      // take coincident with ERET: ERET wins, take follows next cycle
      ir_in[0] = 1'b1; oper = OP_ERET;
      jump_lit("eret_wins", 1'b1, 32'h200);
      tick();
      oper = OP_NONE;
      chk("exl_eret_wins", {31'd0, exl}, 32'd0);
      ret_addr = 32'h300;
      jump_lit("take_after_eret", 1'b1, 32'h20);
      tick();
      ir_in = '0;
      eret();

      // 4: priority of level lines 0 and 3
      store(5'd12, 32'h0000_0901);
      ret_addr = 32'h400; ir_in = 4'b1001;
      jump_lit("take_prio", 1'b1, 32'h20);
      tick();
      ir_in = 4'b0001;
      read_lit("cause_prio3", 5'd13, 32'h0003_0100);
      eret();
      jump_lit("take_prio0", 1'b1, 32'h20);
      tick();
      read_lit("cause_prio0", 5'd13, 32'h0000_0100);
      ir_in = '0;
      eret();

      // 5: STORE suppressed by a coincident take; EBase low bits forced 0
      ret_addr = 32'h500; ir_in = 4'b1000;
      oper = OP_STORE; addr_w = 5'd15; data_w = 32'h400;
      jump_lit("take_store", 1'b1, 32'h20);
      tick();
      oper = OP_NONE; ir_in = '0;
      read_lit("ebase_kept", 5'd15, 32'h20);
      eret();
      store(5'd15, 32'h403);
      read_lit("ebase_write", 5'd15, 32'h400);

      // Opcode 11 behaves as NONE
      oper = 2'b11; addr_w = 5'd14; data_w = 32'hDEAD_BEEF;
      tick();
      oper = OP_NONE;
      read_lit("op11_ignored", 5'd14, 32'h500);
      // Same-cycle read and write of EPC returns the old value
      addr_r = 5'd14;
      store(5'd14, 32'h1234);
      chk("rw_same_old", data_r, 32'h500);
      tick();
      chk("rw_same_new", data_r, 32'h1234);

      // Edge set wins over a same-cycle clear
      store(5'd12, 32'h0000_0200);
      ir_in[1] = 1'b1;
      store(5'd13, 32'h0);
      ir_in[1] = 1'b0;
      read_lit("edge_set_wins", 5'd13, 32'h0003_0200);
      store(5'd13, 32'h0);
      read_lit("edge_cleared", 5'd13, 32'h0003_0000);
      read_lit("status_ie0", 5'd12, 32'h0000_0200);
      read_lit("unmapped", 5'd5, 32'h0);
`ifndef CP0_TIMER_EN
      read_lit("count_absent", 5'd9, 32'h0);
      store(5'd12, 32'hFFFF_FFFF);
      read_lit("status_no_timer_im", 5'd12, 32'h0000_0F03);
      store(5'd12, 32'h0);
`endif

      // Reset in the middle of a handler
      store(5'd12, 32'h0000_0101);
      ir_in[0] = 1'b1;
      tick();
      chk("exl_before_rst", {31'd0, exl}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; ir_in = '0;
      chk("exl_after_rst", {31'd0, exl}, 32'd0);
      read_lit("ebase_after_rst", 5'd15, 32'h20);
      read_lit("status_after_rst", 5'd12, 32'h0);

`ifdef CP0_TIMER_EN
      // 6: timer interrupt
      store(5'd12, 32'h0000_1001);
      store(5'd11, 32'd10);
      store(5'd9, 32'd0);
      hit_n = -1;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (jump_en === 1'b1) begin
            hit_n = n;
            break;
         end
         tick();
      end
      chk("timer_latency", hit_n, 32'd11);
      if (hit_n >= 0) tick();
      read_lit("cause_timer", 5'd13, 32'h0004_1000);
      store(5'd11, 32'd0);
      read_lit("timer_cleared", 5'd13, 32'h0004_0000);
      eret();
`endif
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
